reg_file_sb: RTL and testbench

Parametrised synchronous register file with an asynchronous clear, write-to-read bypass and a per-register busy scoreboard. It is the next-generation register file for the pipelined datapath. Decode reads two source operands and marks destinations pending. Writeback commits results and releases the pending marks. A debug port exposes any register to the display/debug logic.

---
 rtl/reg_file_sb.sv | 111 +++++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write-to-read bypass and busy scoreboard
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] req_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_req,
    input  logic [ADDR_W-1:0] req_a,
    input  logic [ADDR_W-1:0] req_b,
    input  logic [ADDR_W-1:0] req_dbg,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_dbg,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic wr_ok;
    logic mk_ok;
    logic cnt_inc;
    logic cnt_dec;

    logic [ADDR_W-1:0] rd_req  [3];
    logic [DATA_W-1:0] rd_data [3];
    logic              rd_busy [2];

    // Effective commit/mark qualifiers; register 0 is immune when it is hardwired to zero.
    always_comb begin
        wr_ok = en && we && !((ZERO_REG != 0) && (req_w == '0));
        mk_ok = en && sb_set && !((ZERO_REG != 0) && (sb_req == '0));
    end

    // Next busy vector: commit clears, mark sets; mark applied last so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[req_w] = 1'b0;
        end
        if (mk_ok) begin
            busy_nxt[sb_req] = 1'b1;
        end
    end

    // Counter deltas track the population count; a same-index commit+mark never counts a clear.
    always_comb begin
        cnt_inc = mk_ok && !busy[sb_req];
        cnt_dec = wr_ok && busy[req_w] && !(mk_ok && (sb_req == req_w));
    end

    // Storage, busy bits and pending counter; async clear, frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else if (en) begin
            if (wr_ok) begin
                regs[req_w] <= data_w;
            end
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
        end
    end

    assign rd_req[0] = req_a;
    assign rd_req[1] = req_b;
    assign rd_req[2] = req_dbg;

    // Read ports: array value, then zero-register override, then same-cycle commit forwarding.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_data[i] = regs[rd_req[i]];
            if ((ZERO_REG != 0) && (rd_req[i] == '0)) begin
                rd_data[i] = '0;
            end
            if ((BYPASS != 0) && wr_ok && (req_w == rd_req[i])) begin
                rd_data[i] = data_w;
            end
        end
        for (int i = 0; i < 2; i++) begin
            rd_busy[i] = busy[rd_req[i]];
            if ((BYPASS != 0) && wr_ok && (req_w == rd_req[i])) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

    assign data_a   = rd_data[0];
    assign data_b   = rd_data[1];
    assign data_dbg = rd_data[2];
    assign busy_a   = rd_busy[0];
    assign busy_b   = rd_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed bench for reg_file_sb, bypassed and non-bypassed variants
`timescale 1ns/1ps
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [4:0]  req_w;
    logic [31:0] data_w;
    logic        sb_set;
    logic [4:0]  sb_req;
    logic [4:0]  req_a;
    logic [4:0]  req_b;
    logic [4:0]  req_dbg;

    logic [31:0] data_a, data_b, data_dbg;
    logic        busy_a, busy_b;
    logic [5:0]  busy_cnt;

    logic [31:0] nb_data_a, nb_data_b, nb_data_dbg;
    logic        nb_busy_a, nb_busy_b;
    logic [5:0]  nb_busy_cnt;

    int total = 0;
    int bad = 0;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .req_w(req_w), .data_w(data_w),
        .sb_set(sb_set), .sb_req(sb_req), .req_a(req_a), .req_b(req_b), .req_dbg(req_dbg),
        .data_a(data_a), .data_b(data_b), .data_dbg(data_dbg),
        .busy_a(busy_a), .busy_b(busy_b), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_nb (
        .clk(clk), .rst(rst), .en(en), .we(we), .req_w(req_w), .data_w(data_w),
        .sb_set(sb_set), .sb_req(sb_req), .req_a(req_a), .req_b(req_b), .req_dbg(req_dbg),
        .data_a(nb_data_a), .data_b(nb_data_b), .data_dbg(nb_data_dbg),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b), .busy_cnt(nb_busy_cnt)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; sb_set = 1'b0; req_w = '0; data_w = '0; sb_req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; idle_inputs();
        req_a = 5'd3; req_b = 5'd17; req_dbg = 5'd31;
        #20;
        total++; if (data_a !== 32'h0) begin bad++; $display("FAIL reset_data_a got %h want %h", data_a, 32'h0); end
        total++; if (data_b !== 32'h0) begin bad++; $display("FAIL reset_data_b got %h want %h", data_b, 32'h0); end
        total++; if (data_dbg !== 32'h0) begin bad++; $display("FAIL reset_data_dbg got %h want %h", data_dbg, 32'h0); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
        total++; if ({busy_a, busy_b} !== 2'b00) begin bad++; $display("FAIL reset_busy got %b want 00", {busy_a, busy_b}); end
        rst = 1'b0;
        clk_run = 1'b1;
    endtask

    task automatic test_simple_write();
        en = 1'b1; we = 1'b1; req_w = 5'd3; data_w = 32'hDEADBEEF; req_a = 5'd3;
        step();
        idle_inputs();
        #1;
        total++; if (data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_simple got %h want %h", data_a, 32'hDEADBEEF); end
        total++; if (nb_data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_simple_nb got %h want %h", nb_data_a, 32'hDEADBEEF); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; req_w = 5'd0; data_w = 32'h12345678; sb_set = 1'b1; sb_req = 5'd0; req_a = 5'd0;
        #1;
        total++; if (data_a !== 32'h0) begin bad++; $display("FAIL zero_no_bypass got %h want 0", data_a); end
        step();
        idle_inputs();
        #1;
        total++; if (data_a !== 32'h0) begin bad++; $display("FAIL zero_data got %h want 0", data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", busy_a); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL zero_cnt got %0d want 0", busy_cnt); end
    endtask

    task automatic test_bypass();
        we = 1'b1; req_w = 5'd5; data_w = 32'h1;
        step();
        data_w = 32'h2; req_a = 5'd5; req_b = 5'd5; req_dbg = 5'd5;
        #1;
        total++; if (data_a !== 32'h2) begin bad++; $display("FAIL byp_a got %h want 2", data_a); end
        total++; if (data_b !== 32'h2) begin bad++; $display("FAIL byp_b got %h want 2", data_b); end
        total++; if (data_dbg !== 32'h2) begin bad++; $display("FAIL byp_dbg got %h want 2", data_dbg); end
        total++; if (nb_data_a !== 32'h1) begin bad++; $display("FAIL nobyp_before got %h want 1", nb_data_a); end
        step();
        idle_inputs();
        #1;
        total++; if (nb_data_a !== 32'h2) begin bad++; $display("FAIL nobyp_after got %h want 2", nb_data_a); end
        total++; if (data_b !== 32'h2) begin bad++; $display("FAIL byp_after got %h want 2", data_b); end
    endtask

    task automatic test_scoreboard();
        logic [5:0] exp_cnt [3];
        logic [4:0] marks [3];
        marks[0] = 5'd4; marks[1] = 5'd7; marks[2] = 5'd4;
        exp_cnt[0] = 6'd1; exp_cnt[1] = 6'd2; exp_cnt[2] = 6'd2;
        for (int i = 0; i < 3; i++) begin
            sb_set = 1'b1; sb_req = marks[i];
            step();
            total++; if (busy_cnt !== exp_cnt[i]) begin bad++; $display("FAIL sb_mark%0d got %0d want %0d", i, busy_cnt, exp_cnt[i]); end
        end
        idle_inputs();
        req_a = 5'd4; req_b = 5'd7;
        #1;
        total++; if ({busy_a, busy_b} !== 2'b11) begin bad++; $display("FAIL sb_busy_ab got %b want 11", {busy_a, busy_b}); end
        we = 1'b1; req_w = 5'd4; data_w = 32'h44; sb_set = 1'b1; sb_req = 5'd4;
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL sb_byp_busy got %b want 0", busy_a); end
        total++; if (nb_busy_a !== 1'b1) begin bad++; $display("FAIL sb_nobyp_busy got %b want 1", nb_busy_a); end
        step();
        idle_inputs();
        #1;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL sb_same_busy got %b want 1", busy_a); end
        total++; if (busy_cnt !== 6'd2) begin bad++; $display("FAIL sb_same_cnt got %0d want 2", busy_cnt); end
        total++; if (data_a !== 32'h44) begin bad++; $display("FAIL sb_same_data got %h want 44", data_a); end
        we = 1'b1; req_w = 5'd7; data_w = 32'h77;
        step();
        idle_inputs();
        #1;
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL sb_clr7_busy got %b want 0", busy_b); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_clr7_cnt got %0d want 1", busy_cnt); end
        total++; if (nb_busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_clr7_cnt_nb got %0d want 1", nb_busy_cnt); end
        we = 1'b1; req_w = 5'd6; data_w = 32'h66; req_b = 5'd6;
        step();
        idle_inputs();
        #1;
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL sb_nonbusy_cnt got %0d want 1", busy_cnt); end
        total++; if ({busy_b, data_b} !== {1'b0, 32'h66}) begin bad++; $display("FAIL sb_nonbusy got %b/%h want 0/66", busy_b, data_b); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; req_w = 5'(20 + i); data_w = 32'hA000_0000 + 32'(i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            req_dbg = 5'(20 + i);
            #1;
            total++; if (data_dbg !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL b2b_%0d got %h want %h", i, data_dbg, 32'hA000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_stall();
        we = 1'b1; req_w = 5'd9; data_w = 32'h55;
        step();
        en = 1'b0; we = 1'b1; req_w = 5'd9; data_w = 32'hAA; sb_set = 1'b1; sb_req = 5'd9; req_a = 5'd9;
        #1;
        total++; if (data_a !== 32'h55) begin bad++; $display("FAIL stall_no_bypass got %h want 55", data_a); end
        step();
        total++; if (data_a !== 32'h55) begin bad++; $display("FAIL stall_data got %h want 55", data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL stall_busy got %b want 0", busy_a); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL stall_cnt got %0d want 1", busy_cnt); end
        en = 1'b1; idle_inputs();
    endtask

    task automatic test_reset_mid();
        sb_set = 1'b1; sb_req = 5'd10;
        step();
        sb_req = 5'd11;
        step();
        idle_inputs();
        total++; if (busy_cnt !== 6'd3) begin bad++; $display("FAIL mid_pre_cnt got %0d want 3", busy_cnt); end
        req_a = 5'd4; req_b = 5'd9; req_dbg = 5'd3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({data_a, data_b, data_dbg} !== 96'h0) begin bad++; $display("FAIL mid_data got %h/%h/%h want 0", data_a, data_b, data_dbg); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_cnt got %0d want 0", busy_cnt); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy_a); end
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; req_w = 5'd12; data_w = 32'h00C0FFEE; req_a = 5'd12;
        step();
        idle_inputs();
        #1;
        total++; if (data_a !== 32'h00C0FFEE) begin bad++; $display("FAIL mid_post_wr got %h want 00c0ffee", data_a); end
    endtask

    initial begin
        test_reset();
        test_simple_write();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
